// File: rtl/biquad_mac.sv
// ---------------------------------------------------------------------------
// biquad_mac
//
// Sequencing and accumulation stage for a direct-form-I biquad built around
// an external 9x9 unsigned pipelined multiplier (latency MUL_LAT, enabled by
// mul_en). One signed Q1.8 sample is accepted at a time and
//   y = b0*x0 + b1*x1 + b2*x2 - a1*y1 - a2*y2
// is formed by issuing five magnitude pairs to the multiplier. The sign of
// every product travels in a tag pipeline that mirrors the multiplier. The
// returned products are accumulated, then shifted and saturated to 9 bits.
//
// Build option:
//   BIQUAD_MAC_ROUND_EN  defined -> round-half-up before saturation
//                        undefined -> truncation (floor)
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   sample_in[8:0]      signed Q1.8 input sample x0
//   sample_valid        sample offered (accepted when sample_ready is high)
//   sample_ready        high only while idle
//   coef_b0..coef_a2    signed Q3.6 coefficients, latched on accept
//   hist_clr            zero x1/x2/y1/y2 (idle only)
//   y_out[8:0]          signed Q1.8 result, registered
//   y_valid             one-cycle pulse alongside a new y_out
//   mul_en              multiplier pipeline enable
//   mul_a, mul_b        unsigned operand magnitudes to the multiplier
//   mul_p[17:0]         unsigned product from the multiplier
// ---------------------------------------------------------------------------
module biquad_mac #(
  parameter int MUL_LAT   = 5,   // must be >= 2
  parameter int ACC_W     = 21,
  parameter int OUT_SHIFT = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [8:0]  sample_in,
  input  logic        sample_valid,
  output logic        sample_ready,
  input  logic [8:0]  coef_b0,
  input  logic [8:0]  coef_b1,
  input  logic [8:0]  coef_b2,
  input  logic [8:0]  coef_a1,
  input  logic [8:0]  coef_a2,
  input  logic        hist_clr,
  output logic [8:0]  y_out,
  output logic        y_valid,
  output logic        mul_en,
  output logic [8:0]  mul_a,
  output logic [8:0]  mul_b,
  input  logic [17:0] mul_p
);

  localparam int DCW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
  localparam logic [DCW-1:0] DRAIN_LAST = DCW'(MUL_LAT - 1);
  localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(255);
  localparam logic signed [ACC_W-1:0] SAT_LO = -ACC_W'(256);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_OUT
  } state_t;

  state_t                    state_q;
  logic [2:0]                issue_cnt_q;
  logic [DCW-1:0]            drain_cnt_q;

  // Latched operands for the current sample and the filter history.
  logic [8:0]                x0_q, x1_q, x2_q, y1_q, y2_q;
  logic [8:0]                b0_q, b1_q, b2_q, a1_q, a2_q;

  logic signed [ACC_W-1:0]   acc_q;
  logic signed [ACC_W-1:0]   acc_d;

  // Operand register feeding the multiplier plus the tag of that operand.
  logic [8:0]                mul_a_q, mul_b_q;
  logic                      op_v_q, op_s_q;
  logic                      mul_en_q;

  // Tag pipeline: bit MUL_LAT-1 describes the product currently on mul_p.
  logic [MUL_LAT-1:0]        tag_v_q, tag_s_q;

  logic [8:0]                y_out_q;
  logic                      y_valid_q;

  // Operand selection for pairs 1..4 (pair 0 comes straight from the inputs).
  logic [8:0]                sel_s, sel_c;
  logic                      sel_neg;

  logic signed [ACC_W-1:0]   prod_ext;
  logic signed [ACC_W-1:0]   acc_pre;
  logic signed [ACC_W-1:0]   acc_shr;
  logic [8:0]                y_sat;

  function automatic logic [8:0] mag9(input logic [8:0] v);
    // Two's-complement magnitude; -256 maps to 256, which fits unsigned 9 bits.
    return v[8] ? (~v + 9'd1) : v;
  endfunction

  always_comb begin
    sel_s   = 9'd0;
    sel_c   = 9'd0;
    sel_neg = 1'b0;
    case (issue_cnt_q)
      3'd1: begin sel_s = x1_q; sel_c = b1_q; end
      3'd2: begin sel_s = x2_q; sel_c = b2_q; end
      3'd3: begin sel_s = y1_q; sel_c = a1_q; sel_neg = 1'b1; end
      3'd4: begin sel_s = y2_q; sel_c = a2_q; sel_neg = 1'b1; end
      default: begin sel_s = 9'd0; sel_c = 9'd0; sel_neg = 1'b0; end
    endcase
  end

  // Accumulate whichever product is emerging from the multiplier this cycle.
  always_comb begin
    prod_ext = {{(ACC_W-18){1'b0}}, mul_p};
    acc_d    = acc_q;
    if (mul_en_q && tag_v_q[MUL_LAT-1]) begin
      acc_d = tag_s_q[MUL_LAT-1] ? (acc_q - prod_ext) : (acc_q + prod_ext);
    end
  end

  // Output formation works on acc_d so the result can be registered on the
  // same edge that captures the final product.
  always_comb begin
`ifdef BIQUAD_MAC_ROUND_EN
    acc_pre = acc_d + (ACC_W'(1) <<< (OUT_SHIFT - 1));
`else
    acc_pre = acc_d;
`endif
    acc_shr = acc_pre >>> OUT_SHIFT;
    if (acc_shr > SAT_HI) begin
      y_sat = 9'h0FF;
    end else if (acc_shr < SAT_LO) begin
      y_sat = 9'h100;
    end else begin
      y_sat = acc_shr[8:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      issue_cnt_q <= 3'd0;
      drain_cnt_q <= '0;
      x0_q        <= 9'd0;
      x1_q        <= 9'd0;
      x2_q        <= 9'd0;
      y1_q        <= 9'd0;
      y2_q        <= 9'd0;
      b0_q        <= 9'd0;
      b1_q        <= 9'd0;
      b2_q        <= 9'd0;
      a1_q        <= 9'd0;
      a2_q        <= 9'd0;
      acc_q       <= '0;
      mul_a_q     <= 9'd0;
      mul_b_q     <= 9'd0;
      op_v_q      <= 1'b0;
      op_s_q      <= 1'b0;
      mul_en_q    <= 1'b0;
      tag_v_q     <= '0;
      tag_s_q     <= '0;
      y_out_q     <= 9'd0;
      y_valid_q   <= 1'b0;
    end else begin
      // Tags advance in lockstep with the multiplier pipeline.
      if (mul_en_q) begin
        tag_v_q <= {tag_v_q[MUL_LAT-2:0], op_v_q};
        tag_s_q <= {tag_s_q[MUL_LAT-2:0], op_s_q};
      end

      case (state_q)
        S_IDLE: begin
          y_valid_q <= 1'b0;
          if (hist_clr) begin
            x1_q <= 9'd0;
            x2_q <= 9'd0;
            y1_q <= 9'd0;
            y2_q <= 9'd0;
          end
          if (sample_valid) begin
            x0_q        <= sample_in;
            b0_q        <= coef_b0;
            b1_q        <= coef_b1;
            b2_q        <= coef_b2;
            a1_q        <= coef_a1;
            a2_q        <= coef_a2;
            acc_q       <= '0;
            // Pair 0 only needs the incoming sample, so it goes out now.
            mul_a_q     <= mag9(sample_in);
            mul_b_q     <= mag9(coef_b0);
            op_v_q      <= 1'b1;
            op_s_q      <= sample_in[8] ^ coef_b0[8];
            mul_en_q    <= 1'b1;
            issue_cnt_q <= 3'd1;
            state_q     <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          acc_q <= acc_d;
          if (issue_cnt_q == 3'd5) begin
            mul_a_q     <= 9'd0;
            mul_b_q     <= 9'd0;
            op_v_q      <= 1'b0;
            op_s_q      <= 1'b0;
            drain_cnt_q <= '0;
            state_q     <= S_DRAIN;
          end else begin
            mul_a_q     <= mag9(sel_s);
            mul_b_q     <= mag9(sel_c);
            op_v_q      <= 1'b1;
            op_s_q      <= sel_s[8] ^ sel_c[8] ^ sel_neg;
            issue_cnt_q <= issue_cnt_q + 3'd1;
          end
        end

        S_DRAIN: begin
          acc_q <= acc_d;
          if (drain_cnt_q == DRAIN_LAST) begin
            y_out_q   <= y_sat;
            y_valid_q <= 1'b1;
            mul_en_q  <= 1'b0;
            x2_q      <= x1_q;
            x1_q      <= x0_q;
            y2_q      <= y1_q;
            y1_q      <= y_sat;
            state_q   <= S_OUT;
          end else begin
            drain_cnt_q <= drain_cnt_q + DCW'(1);
          end
        end

        S_OUT: begin
          y_valid_q <= 1'b0;
          state_q   <= S_IDLE;
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign sample_ready = (state_q == S_IDLE);
  assign y_out        = y_out_q;
  assign y_valid      = y_valid_q;
  assign mul_en       = mul_en_q;
  assign mul_a        = mul_a_q;
  assign mul_b        = mul_b_q;

endmodule

// File: tb/tb_biquad_mac.sv
// ---------------------------------------------------------------------------
// tb_biquad_mac
//
// Directed testbench for biquad_mac. A behavioural 5-stage multiplier model
// stands in for biquad_v2. Each scenario is a task with its own inline
// comparisons; expected results are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_biquad_mac;

  logic        clk;
  logic        rst_n;
  logic [8:0]  sample_in;
  logic        sample_valid;
  logic        sample_ready;
  logic [8:0]  coef_b0, coef_b1, coef_b2, coef_a1, coef_a2;
  logic        hist_clr;
  logic [8:0]  y_out;
  logic        y_valid;
  logic        mul_en;
  logic [8:0]  mul_a, mul_b;
  logic [17:0] mul_p;

  int tests_run;
  int tests_failed;

  biquad_mac dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .coef_b0      (coef_b0),
    .coef_b1      (coef_b1),
    .coef_b2      (coef_b2),
    .coef_a1      (coef_a1),
    .coef_a2      (coef_a2),
    .hist_clr     (hist_clr),
    .y_out        (y_out),
    .y_valid      (y_valid),
    .mul_en       (mul_en),
    .mul_a        (mul_a),
    .mul_b        (mul_b),
    .mul_p        (mul_p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Multiplier model: operands in cycle c produce mul_p in cycle c+5.
  logic [17:0] pipe [0:4];
  initial for (int i = 0; i < 5; i++) pipe[i] = 18'd0;
  always @(posedge clk) begin
    if (mul_en) begin
      pipe[0] <= 18'(mul_a) * 18'(mul_b);
      for (int i = 1; i < 5; i++) pipe[i] <= pipe[i-1];
    end
  end
  assign mul_p = pipe[4];

  function automatic logic [8:0] mag(input logic [8:0] v);
    return v[8] ? (~v + 9'd1) : v;
  endfunction

  task automatic set_coefs(input logic [8:0] b0, input logic [8:0] b1, input logic [8:0] b2,
                           input logic [8:0] a1, input logic [8:0] a2);
    coef_b0 = b0; coef_b1 = b1; coef_b2 = b2; coef_a1 = a1; coef_a2 = a2;
  endtask

  // Offers x in the current cycle (which must be idle) and follows the
  // sample through cycle 12. Coefficient inputs are scrambled while busy to
  // confirm they were latched. poke>0 offers a junk sample in that cycle.
  task automatic run_sample(input logic [8:0] x, input logic [8:0] exp_y,
                            input logic clr, input int poke, input string name);
    logic [8:0] sb0, sb1, sb2, sa1, sa2;
    sb0 = coef_b0; sb1 = coef_b1; sb2 = coef_b2; sa1 = coef_a1; sa2 = coef_a2;
    tests_run++;
    if (sample_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL %s ready_before_accept got=%b want=1", name, sample_ready);
    end
    sample_in    = x;
    sample_valid = 1'b1;
    hist_clr     = clr;
    @(posedge clk); #1;
    sample_valid = 1'b0;
    hist_clr     = 1'b0;
    sample_in    = 9'h0AA;
    set_coefs(9'h155, 9'h155, 9'h155, 9'h155, 9'h155);
    for (int c = 1; c <= 12; c++) begin
      if (poke != 0 && c == poke) begin
        sample_in    = 9'h0C8;
        sample_valid = 1'b1;
      end
      if (poke != 0 && c == poke + 1) sample_valid = 1'b0;
      if (c == 1) begin
        tests_run++;
        if (mul_a !== mag(x) || mul_b !== mag(sb0)) begin
          tests_failed++;
          $display("FAIL %s pair0 got a=%0d b=%0d want a=%0d b=%0d",
                   name, mul_a, mul_b, mag(x), mag(sb0));
        end
      end
      tests_run++;
      if (y_valid !== (c == 11)) begin
        tests_failed++;
        $display("FAIL %s y_valid cycle %0d got=%b want=%b", name, c, y_valid, (c == 11));
      end
      tests_run++;
      if (mul_en !== (c <= 10)) begin
        tests_failed++;
        $display("FAIL %s mul_en cycle %0d got=%b want=%b", name, c, mul_en, (c <= 10));
      end
      tests_run++;
      if (sample_ready !== (c == 12)) begin
        tests_failed++;
        $display("FAIL %s sample_ready cycle %0d got=%b want=%b", name, c, sample_ready, (c == 12));
      end
      if (c == 11) begin
        tests_run++;
        if (y_out !== exp_y) begin
          tests_failed++;
          $display("FAIL %s y_out got=%0d want=%0d", name, $signed(y_out), $signed(exp_y));
        end
        $display("[TB] %s x=%0d y_out=%0d expected=%0d", name, $signed(x), $signed(y_out), $signed(exp_y));
      end
      if (c < 12) begin
        @(posedge clk); #1;
      end
    end
    set_coefs(sb0, sb1, sb2, sa1, sa2);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    sample_in = 9'd0; sample_valid = 1'b0; hist_clr = 1'b0;
    set_coefs(9'd0, 9'd0, 9'd0, 9'd0, 9'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    tests_run++;
    if (y_out !== 9'd0 || y_valid !== 1'b0 || mul_en !== 1'b0 ||
        mul_a !== 9'd0 || mul_b !== 9'd0 || sample_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_state got y=%0d v=%b en=%b a=%0d b=%0d rdy=%b want 0 0 0 0 0 1",
               y_out, y_valid, mul_en, mul_a, mul_b, sample_ready);
    end
    $display("[TB] reset state checked");
  endtask

  task automatic test_pass_through();
    set_coefs(9'd64, 9'd0, 9'd0, 9'd0, 9'd0);
    run_sample(9'd100, 9'd100, 1'b0, 0, "pass_through");
  endtask

  task automatic test_saturation();
    set_coefs(9'h1C0, 9'd0, 9'd0, 9'd0, 9'd0);      // b0 = -64
    run_sample(9'h100, 9'h0FF, 1'b0, 0, "sat_neg_neg");
    set_coefs(9'd127, 9'd0, 9'd0, 9'd0, 9'd0);
    run_sample(9'd255, 9'h0FF, 1'b0, 0, "sat_pos_506");
    set_coefs(9'h180, 9'd0, 9'd0, 9'd0, 9'd0);      // b0 = -128
    run_sample(9'd255, 9'h100, 1'b0, 0, "sat_neg_510");
  endtask

  task automatic test_recursion();
    set_coefs(9'd64, 9'd0, 9'd0, 9'h1E0, 9'd0);     // a1 = -32
    run_sample(9'd128, 9'd128, 1'b1, 0, "recur0");   // clear stale history
    run_sample(9'd0, 9'd64, 1'b0, 0, "recur1");
    run_sample(9'd0, 9'd32, 1'b0, 0, "recur2");
    run_sample(9'd0, 9'd16, 1'b0, 0, "recur3");
  endtask

  task automatic test_hist_clr();
    // y1=16 from recursion would give 8 without the clear.
    run_sample(9'd0, 9'd0, 1'b1, 0, "hist_clr");
  endtask

  task automatic test_rounding();
    set_coefs(9'd1, 9'd0, 9'd0, 9'd0, 9'd0);
`ifdef BIQUAD_MAC_ROUND_EN
    run_sample(9'd96, 9'd2, 1'b0, 0, "round_pos");
    run_sample(9'h1A0, 9'h1FF, 1'b0, 0, "round_neg");   // -1
`else
    run_sample(9'd96, 9'd1, 1'b0, 0, "round_pos");
    run_sample(9'h1A0, 9'h1FE, 1'b0, 0, "round_neg");   // -2
`endif
  endtask

  task automatic test_busy();
    set_coefs(9'd64, 9'd0, 9'd0, 9'd0, 9'd0);
    run_sample(9'd50, 9'd50, 1'b0, 3, "busy_ignore");
    @(posedge clk); #1;
    tests_run++;
    if (mul_en !== 1'b0 || sample_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL busy_no_restart got en=%b rdy=%b want 0 1", mul_en, sample_ready);
    end
  endtask

  task automatic test_reset_mid();
    int pulses;
    // History holds x1=50, y1=50; with these coefs a stale history adds 75.
    set_coefs(9'd64, 9'd64, 9'd0, 9'h1E0, 9'd0);
    sample_in = 9'd100; sample_valid = 1'b1;
    @(posedge clk); #1;
    sample_valid = 1'b0;
    repeat (7) begin @(posedge clk); #1; end          // now in cycle 8
    tests_run++;
    if (mul_en !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_mid_busy got en=%b want 1", mul_en);
    end
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (mul_en !== 1'b0 || y_valid !== 1'b0 || mul_a !== 9'd0) begin
      tests_failed++;
      $display("FAIL reset_mid_async got en=%b v=%b a=%0d want 0 0 0", mul_en, y_valid, mul_a);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    pulses = 0;
    repeat (14) begin
      @(posedge clk); #1;
      if (y_valid === 1'b1) pulses++;
    end
    tests_run++;
    if (pulses != 0) begin
      tests_failed++;
      $display("FAIL reset_mid_no_pulse got=%0d pulses want=0", pulses);
    end
    $display("[TB] reset mid-sample, y_valid pulses after reset=%0d", pulses);
    run_sample(9'd100, 9'd100, 1'b0, 0, "post_reset_hist");
  endtask

  task automatic test_back_to_back();
    // b0=64 b1=32 b2=-16 a1=16 a2=-8: expected 64, -48, 4 from zero history.
    set_coefs(9'd64, 9'd32, 9'h1F0, 9'd16, 9'h1F8);
    run_sample(9'd64, 9'd64, 1'b1, 0, "b2b0");
    run_sample(9'h1C0, 9'h1D0, 1'b0, 0, "b2b1");      // x=-64 -> -48
    run_sample(9'd32, 9'd4, 1'b0, 0, "b2b2");
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_pass_through();
    test_saturation();
    test_recursion();
    test_hist_clr();
    test_rounding();
    test_busy();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
